mm_iddmm_ctrl: RTL and testbench

//   Sequencer for one IDDMM processing element (mm_iddmm_pe). Accepts a start pulse, then walks

---
 rtl/mm_iddmm_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mm_iddmm_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_iddmm_ctrl.sv
// Sequencer for one IDDMM processing element. After a start pulse it walks the
// outer index i over 0..N-1 and the inner index j over 0..N. For each (i, j) it
// issues operand-RAM reads, and one cycle later presents the matching PE controls,
// zero-forcing flags and a-RAM write-back. The one-cycle delay lines the PE
// controls up with the synchronous RAM read data. This block does no arithmetic.
module mm_iddmm_ctrl #(
   parameter int K = 128,
   parameter int N = 32,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          rd_en,
   output logic [AW-1:0] x_raddr,
   output logic [AW-1:0] m_raddr,
   output logic [AW-1:0] a_raddr,
   output logic [AW-1:0] y_raddr,
   output logic [AW-1:0] pe_i,
   output logic [AW:0]   pe_j,
   output logic          pe_j00,
   output logic          x_zero,
   output logic          m_zero,
   output logic          a_zero,
   output logic          a_we,
   output logic [AW-1:0] a_waddr
);

   // The address arithmetic assumes a power-of-two word count of at least two.
   // K only documents the datapath word width.
   if (N < 2 || (N & (N - 1)) != 0 || K < 1) begin : gParamCheck
      $error("mm_iddmm_ctrl: N must be a power of two >= 2 and K >= 1");
   end

   localparam logic [AW:0]   JLAST = (AW+1)'(N);
   localparam logic [AW-1:0] ILAST = AW'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      J00,
      ROW,
      DRAIN,
      FIN
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] row_q, row_d;
   logic [AW:0]   col_q, col_d;

   logic          issueValid;
   logic          issueJ00;
   logic          issueRd;
   logic [AW:0]   issueJ;
   logic [AW-1:0] issueIdx;

   logic [AW-1:0] peI_q, peI_d;
   logic [AW:0]   peJ_q, peJ_d;
   logic          peJ00_q, peJ00_d;
   logic          xmZero_q, xmZero_d;
   logic          aZero_q, aZero_d;
   logic          aWe_q, aWe_d;
   logic [AW-1:0] aWaddr_q, aWaddr_d;

   // Issue-stage state and indices; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // Next-state logic: J00 issues the j=0 pre-step, ROW sweeps j=0..N, then the
   // row index advances or the sequence drains. start is only honoured in IDLE.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = J00;
               row_d   = '0;
               col_d   = '0;
            end
         end
         J00: begin
            state_d = ROW;
            col_d   = '0;
         end
         ROW: begin
            if (col_q != JLAST) begin
               col_d = col_q + 1'b1;
            end else if (row_q != ILAST) begin
               row_d   = row_q + 1'b1;
               col_d   = '0;
               state_d = J00;
            end else begin
               row_d   = '0;
               col_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: state_d = FIN;
         FIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Issue-stage decode: read strobes and addresses, plus the values that the
   // PE stage will see one cycle later. At j==N no RAM word exists, so rd_en drops.
   always_comb begin
      issueValid = (state_q == J00) || (state_q == ROW);
      issueJ00   = (state_q == J00);
      issueJ     = (state_q == ROW) ? col_q : '0;
      issueIdx   = issueJ[AW-1:0];
      issueRd    = issueJ00 || ((state_q == ROW) && (col_q != JLAST));

      peI_d    = issueValid ? row_q : '0;
      peJ_d    = issueJ;
      peJ00_d  = issueJ00;
      xmZero_d = issueValid && (issueJ == JLAST);
      aZero_d  = issueValid && ((row_q == '0) || (issueJ == JLAST));
      aWe_d    = issueValid && !issueJ00 && (issueJ != '0);
      // For j==N the low bits are zero, so subtracting one wraps to N-1 as intended.
      aWaddr_d = aWe_d ? (issueIdx - 1'b1) : '0;
   end

   // PE stage: the issue values delayed once to align with RAM read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peI_q    <= '0;
         peJ_q    <= '0;
         peJ00_q  <= 1'b0;
         xmZero_q <= 1'b0;
         aZero_q  <= 1'b0;
         aWe_q    <= 1'b0;
         aWaddr_q <= '0;
      end else begin
         peI_q    <= peI_d;
         peJ_q    <= peJ_d;
         peJ00_q  <= peJ00_d;
         xmZero_q <= xmZero_d;
         aZero_q  <= aZero_d;
         aWe_q    <= aWe_d;
         aWaddr_q <= aWaddr_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == FIN);
   assign rd_en   = issueRd;
   assign x_raddr = issueRd ? issueIdx : '0;
   assign m_raddr = issueRd ? issueIdx : '0;
   assign a_raddr = issueRd ? issueIdx : '0;
   assign y_raddr = issueValid ? row_q : '0;
   assign pe_i    = peI_q;
   assign pe_j    = peJ_q;
   assign pe_j00  = peJ00_q;
   assign x_zero  = xmZero_q;
   assign m_zero  = xmZero_q;
   assign a_zero  = aZero_q;
   assign a_we    = aWe_q;
   assign a_waddr = aWaddr_q;

endmodule

// File: tb/tb_mm_iddmm_ctrl.sv
// Directed bench for the IDDMM sequencer: an N=4 instance for most scenarios and
// an N=2 instance for the small-operand case.
module tb_mm_iddmm_ctrl;

   localparam int N     = 4;
   localparam int TOTAL = N * (N + 2);
   localparam int LAT   = TOTAL + 2;
   localparam int N2    = 2;
   localparam int LAT2  = N2 * (N2 + 2) + 2;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic start2;

   logic       busy, done, rdEn, peJ00, xZero, mZero, aZero, aWe;
   logic [1:0] xRaddr, mRaddr, aRaddr, yRaddr, peI, aWaddr;
   logic [2:0] peJ;

   logic       busy2, done2, rdEn2, peJ002, xZero2, mZero2, aZero2, aWe2;
   logic [0:0] xRaddr2, mRaddr2, aRaddr2, yRaddr2, peI2, aWaddr2;
   logic [1:0] peJ2;

   int vectorCount = 0;
   int missCount   = 0;

   logic [10:0] issueObs;
   logic [9:0]  peObs;
   logic [22:0] allObs;
   logic [14:0] allObs2;

   assign issueObs = {busy, done, rdEn, xRaddr, mRaddr, aRaddr, yRaddr};
   assign peObs    = {peI, peJ, peJ00, xZero, mZero, aZero, aWe};
   assign allObs   = {issueObs, peObs, aWaddr};
   assign allObs2  = {busy2, done2, rdEn2, xRaddr2, mRaddr2, aRaddr2, yRaddr2,
                      peI2, peJ2, peJ002, xZero2, mZero2, aZero2, aWe2, aWaddr2};

   always #5 clk = ~clk;

   mm_iddmm_ctrl #(.K(128), .N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rdEn),
      .x_raddr(xRaddr), .m_raddr(mRaddr), .a_raddr(aRaddr), .y_raddr(yRaddr),
      .pe_i(peI), .pe_j(peJ), .pe_j00(peJ00), .x_zero(xZero), .m_zero(mZero),
      .a_zero(aZero), .a_we(aWe), .a_waddr(aWaddr)
   );

   mm_iddmm_ctrl #(.K(128), .N(N2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .rd_en(rdEn2),
      .x_raddr(xRaddr2), .m_raddr(mRaddr2), .a_raddr(aRaddr2), .y_raddr(yRaddr2),
      .pe_i(peI2), .pe_j(peJ2), .pe_j00(peJ002), .x_zero(xZero2), .m_zero(mZero2),
      .a_zero(aZero2), .a_we(aWe2), .a_waddr(aWaddr2)
   );

   // Reset forces every output of both instances to zero, and IDLE stays quiet.
   task automatic test_reset;
      rst    = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;
      #2;
      vectorCount++;
      if (allObs !== 23'd0) begin
         missCount++;
         $display("[TB] FAIL reset_outputs: got %h expected 0", allObs);
      end
      vectorCount++;
      if (allObs2 !== 15'd0) begin
         missCount++;
         $display("[TB] FAIL reset_outputs_n2: got %h expected 0", allObs2);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vectorCount++;
      if (allObs !== 23'd0) begin
         missCount++;
         $display("[TB] FAIL idle_outputs: got %h expected 0", allObs);
      end
   endtask

   // Full N=4 operation checked cycle by cycle against a cycle-indexed model.
   task automatic test_full_operation;
      int k, q, row, p, prow, pp, pj, addr, weCount, doneAt;
      logic expRd, expJ00, expXz, expAz, expWe;
      logic [10:0] expIssue;
      logic [9:0]  expPe;
      weCount = 0;
      doneAt  = -1;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= LAT + 3; cyc++) begin
         @(negedge clk);
         k = cyc - 1;
         q = cyc - 2;
         expRd = 1'b0; addr = 0; y_row_clear: row = 0;
         if (k < TOTAL) begin
            row   = k / (N + 2);
            p     = k % (N + 2);
            expRd = (p <= N);
            addr  = (expRd && p > 0) ? p - 1 : 0;
         end
         expIssue = {(cyc <= LAT), (cyc == LAT), expRd, 2'(addr), 2'(addr), 2'(addr), 2'(row)};
         prow = 0; pj = 0; expJ00 = 1'b0; expXz = 1'b0; expAz = 1'b0; expWe = 1'b0;
         if (q >= 0 && q < TOTAL) begin
            prow   = q / (N + 2);
            pp     = q % (N + 2);
            expJ00 = (pp == 0);
            pj     = (pp == 0) ? 0 : pp - 1;
            expXz  = (pj == N);
            expAz  = (prow == 0) || (pj == N);
            expWe  = !expJ00 && (pj >= 1);
         end
         expPe = {2'(prow), 3'(pj), expJ00, expXz, expXz, expAz, expWe};
         vectorCount++;
         if (issueObs !== expIssue) begin
            missCount++;
            $display("[TB] FAIL issue_stage cyc %0d: got %b expected %b", cyc, issueObs, expIssue);
         end
         vectorCount++;
         if (peObs !== expPe) begin
            missCount++;
            $display("[TB] FAIL pe_stage cyc %0d: got %b expected %b", cyc, peObs, expPe);
         end
         if (expWe) begin
            vectorCount++;
            if (aWaddr !== 2'(pj - 1)) begin
               missCount++;
               $display("[TB] FAIL a_waddr cyc %0d: got %0d expected %0d", cyc, aWaddr, pj - 1);
            end
         end
         if (aWe === 1'b1) weCount++;
         if (done === 1'b1 && doneAt < 0) doneAt = cyc;
      end
      vectorCount++;
      if (weCount != N * N) begin
         missCount++;
         $display("[TB] FAIL a_we_count: got %0d expected %0d", weCount, N * N);
      end
      vectorCount++;
      if (doneAt != LAT) begin
         missCount++;
         $display("[TB] FAIL done_latency: got %0d expected %0d", doneAt, LAT);
      end
   endtask

   // Hand-written PE-stage trace of row i=1, plus a_zero held through row 0.
   task automatic test_row_trace;
      logic       j00Tab [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [2:0] jTab   [6] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      logic       weTab  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [1:0] waTab  [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
      logic       xzTab  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [9:0] expPe;
      int idx;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 13; cyc++) begin
         @(negedge clk);
         if (cyc >= 2 && cyc <= 7) begin
            vectorCount++;
            if (aZero !== 1'b1) begin
               missCount++;
               $display("[TB] FAIL a_zero_row0 cyc %0d: got %b expected 1", cyc, aZero);
            end
         end
         if (cyc >= 8) begin
            idx   = cyc - 8;
            expPe = {2'd1, jTab[idx], j00Tab[idx], xzTab[idx], xzTab[idx], xzTab[idx], weTab[idx]};
            vectorCount++;
            if (peObs !== expPe) begin
               missCount++;
               $display("[TB] FAIL row1_trace step %0d: got %b expected %b", idx, peObs, expPe);
            end
            if (weTab[idx]) begin
               vectorCount++;
               if (aWaddr !== waTab[idx]) begin
                  missCount++;
                  $display("[TB] FAIL row1_waddr step %0d: got %0d expected %0d", idx, aWaddr, waTab[idx]);
               end
            end
         end
      end
      for (int c = 0; c < 100 && done !== 1'b1; c++) @(negedge clk);
      vectorCount++;
      if (done !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL row_trace_done: got %b expected 1", done);
      end
      @(negedge clk);
   endtask

   // start held high through the whole run and the FIN cycle is ignored; a fresh
   // start from IDLE then shows the normal latency.
   task automatic test_start_ignored;
      int doneCount, firstDone, lat;
      doneCount = 0;
      firstDone = -1;
      @(negedge clk) start = 1'b1;
      for (int cyc = 1; cyc <= LAT + 4; cyc++) begin
         @(negedge clk);
         if (cyc == LAT + 1) start = 1'b0;
         if (done === 1'b1) begin
            doneCount++;
            if (firstDone < 0) firstDone = cyc;
         end
         if (cyc == LAT + 2) begin
            vectorCount++;
            if (busy !== 1'b0) begin
               missCount++;
               $display("[TB] FAIL start_in_fin_ignored: busy got %b expected 0", busy);
            end
         end
      end
      vectorCount++;
      if (doneCount != 1) begin
         missCount++;
         $display("[TB] FAIL single_done: got %0d expected 1", doneCount);
      end
      vectorCount++;
      if (firstDone != LAT) begin
         missCount++;
         $display("[TB] FAIL held_start_latency: got %0d expected %0d", firstDone, LAT);
      end
      lat = -1;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= LAT + 10; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = c;
            break;
         end
      end
      vectorCount++;
      if (lat != LAT) begin
         missCount++;
         $display("[TB] FAIL restart_latency: got %0d expected %0d", lat, LAT);
      end
      @(negedge clk);
   endtask

   // Asynchronous reset at issue (i=2, j=3) clears everything mid-cycle; the
   // following operation runs to completion normally.
   task automatic test_reset_mid;
      int lat, weCount;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 17; cyc++) @(negedge clk);
      vectorCount++;
      if ({rdEn, yRaddr, xRaddr} !== {1'b1, 2'd2, 2'd3}) begin
         missCount++;
         $display("[TB] FAIL pre_abort_position: got %b expected %b", {rdEn, yRaddr, xRaddr}, {1'b1, 2'd2, 2'd3});
      end
      #2 rst = 1'b1;
      #1;
      vectorCount++;
      if (allObs !== 23'd0) begin
         missCount++;
         $display("[TB] FAIL async_abort: got %h expected 0", allObs);
      end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      vectorCount++;
      if (allObs !== 23'd0) begin
         missCount++;
         $display("[TB] FAIL idle_after_abort: got %h expected 0", allObs);
      end
      lat = -1;
      weCount = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= LAT + 10; c++) begin
         @(negedge clk);
         if (aWe === 1'b1) weCount++;
         if (done === 1'b1) begin
            lat = c;
            break;
         end
      end
      vectorCount++;
      if (lat != LAT) begin
         missCount++;
         $display("[TB] FAIL post_abort_latency: got %0d expected %0d", lat, LAT);
      end
      vectorCount++;
      if (weCount != N * N) begin
         missCount++;
         $display("[TB] FAIL post_abort_writes: got %0d expected %0d", weCount, N * N);
      end
      @(negedge clk);
   endtask

   // N=2 instance: done after 10 cycles, two rows each writing words 0 then 1.
   task automatic test_n2;
      logic [0:0] waTab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [0:0] iTab  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int wr, doneAt;
      wr = 0;
      doneAt = -1;
      @(negedge clk) start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      for (int c = 1; c <= LAT2 + 4; c++) begin
         @(negedge clk);
         if (aWe2 === 1'b1) begin
            if (wr < 4) begin
               vectorCount++;
               if ({peI2, aWaddr2} !== {iTab[wr], waTab[wr]}) begin
                  missCount++;
                  $display("[TB] FAIL n2_write %0d: got i=%0d addr=%0d expected i=%0d addr=%0d",
                           wr, peI2, aWaddr2, iTab[wr], waTab[wr]);
               end
            end
            wr++;
         end
         if (done2 === 1'b1 && doneAt < 0) doneAt = c;
      end
      vectorCount++;
      if (wr != 4) begin
         missCount++;
         $display("[TB] FAIL n2_write_count: got %0d expected 4", wr);
      end
      vectorCount++;
      if (doneAt != LAT2) begin
         missCount++;
         $display("[TB] FAIL n2_latency: got %0d expected %0d", doneAt, LAT2);
      end
   endtask

   initial begin
      test_reset;
      test_full_operation;
      test_row_trace;
      test_start_ignored;
      test_reset_mid;
      test_n2;
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
